// File: rtl/os_latency_monitor.sv
// Multi-channel request/response latency monitor: per-channel IDLE/BUSY tracker
// measuring in_valid->out_valid latency, with a sticky first-error capture.
module os_latency_monitor #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 12,
  parameter int MAX_LAT = 1200,
  parameter int DONE_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         in_valid,
  input  logic [NUM_CH-1:0]         out_valid,
  input  logic                      err_clr,
  output logic [NUM_CH-1:0]         busy,
  output logic [NUM_CH-1:0]         lat_done,
  output logic [NUM_CH*CNT_W-1:0]   lat_value,
  output logic [NUM_CH*CNT_W-1:0]   max_lat,
  output logic [DONE_W-1:0]         done_cnt,
  output logic                      err,
  output logic [3:0]                err_ch,
  output logic [1:0]                err_code
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam logic [1:0] CODE_NONE     = 2'd0;
  localparam logic [1:0] CODE_TIMEOUT  = 2'd1;
  localparam logic [1:0] CODE_SPURIOUS = 2'd2;
  localparam logic [1:0] CODE_OVERLAP  = 2'd3;

  localparam logic [CNT_W-1:0] LAT_LIMIT = CNT_W'(MAX_LAT);

  state_t                     state_q [NUM_CH];
  state_t                     state_d [NUM_CH];
  logic [CNT_W-1:0]           cnt_q   [NUM_CH];
  logic [CNT_W-1:0]           cnt_d   [NUM_CH];
  logic [1:0]                 code_d  [NUM_CH];

  logic [NUM_CH-1:0]          lat_done_q, lat_done_d;
  logic [NUM_CH*CNT_W-1:0]    lat_value_q, lat_value_d;
  logic [NUM_CH*CNT_W-1:0]    max_lat_q, max_lat_d;
  logic [DONE_W-1:0]          done_cnt_q, done_cnt_d;
  logic                       err_q, err_d;
  logic [3:0]                 err_ch_q, err_ch_d;
  logic [1:0]                 err_code_q, err_code_d;

  logic                       err_hit;
  logic [3:0]                 hit_ch;
  logic [1:0]                 hit_code;
  logic [DONE_W-1:0]          done_inc;

  // Per-channel transaction FSMs
  always_comb begin
    lat_done_d  = '0;
    lat_value_d = lat_value_q;
    max_lat_d   = max_lat_q;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      code_d[i]  = CODE_NONE;
      case (state_q[i])
        S_IDLE: begin
          if (in_valid[i] && out_valid[i]) begin
            code_d[i] = CODE_OVERLAP;
          end else if (in_valid[i]) begin
            state_d[i] = S_BUSY;
            cnt_d[i]   = CNT_W'(1);
          end else if (out_valid[i]) begin
            code_d[i] = CODE_SPURIOUS;
          end
        end
        S_BUSY: begin
          if (in_valid[i] && out_valid[i]) begin
            code_d[i]  = CODE_OVERLAP;
            state_d[i] = S_IDLE;
          end else if (out_valid[i]) begin
            state_d[i]                      = S_IDLE;
            lat_done_d[i]                   = 1'b1;
            lat_value_d[i*CNT_W +: CNT_W]   = cnt_q[i];
            if (cnt_q[i] > max_lat_q[i*CNT_W +: CNT_W])
              max_lat_d[i*CNT_W +: CNT_W] = cnt_q[i];
          end else if (in_valid[i]) begin
            code_d[i] = CODE_OVERLAP;
            cnt_d[i]  = cnt_q[i] + 1'b1;
          end else if (cnt_q[i] >= LAT_LIMIT) begin
            // >= keeps a counter pushed past the limit by an overlap from running away
            code_d[i]  = CODE_TIMEOUT;
            state_d[i] = S_IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  // Completion count and lowest-index error selection
  always_comb begin
    done_inc = '0;
    err_hit  = 1'b0;
    hit_ch   = '0;
    hit_code = CODE_NONE;
    for (int i = 0; i < NUM_CH; i++)
      done_inc = done_inc + DONE_W'(lat_done_d[i]);
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (code_d[i] != CODE_NONE) begin
        err_hit  = 1'b1;
        hit_ch   = 4'(i);
        hit_code = code_d[i];
      end
    end
    done_cnt_d = done_cnt_q + done_inc;
  end

  // Sticky capture; a fresh error outranks a coincident clear
  always_comb begin
    err_d      = err_q;
    err_ch_d   = err_ch_q;
    err_code_d = err_code_q;
    if (err_hit && (!err_q || err_clr)) begin
      err_d      = 1'b1;
      err_ch_d   = hit_ch;
      err_code_d = hit_code;
    end else if (err_clr) begin
      err_d      = 1'b0;
      err_ch_d   = '0;
      err_code_d = CODE_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
      lat_done_q  <= '0;
      lat_value_q <= '0;
      max_lat_q   <= '0;
      done_cnt_q  <= '0;
      err_q       <= 1'b0;
      err_ch_q    <= '0;
      err_code_q  <= CODE_NONE;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      lat_done_q  <= lat_done_d;
      lat_value_q <= lat_value_d;
      max_lat_q   <= max_lat_d;
      done_cnt_q  <= done_cnt_d;
      err_q       <= err_d;
      err_ch_q    <= err_ch_d;
      err_code_q  <= err_code_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      busy[i] = (state_q[i] == S_BUSY);
  end

  assign lat_done  = lat_done_q;
  assign lat_value = lat_value_q;
  assign max_lat   = max_lat_q;
  assign done_cnt  = done_cnt_q;
  assign err       = err_q;
  assign err_ch    = err_ch_q;
  assign err_code  = err_code_q;

endmodule
